// File: rtl/switch_debounce.sv
// Push-switch debouncer: 2-flop synchronizer, 4-state stability FSM, press/release pulses.
// Optional long-press detector enabled by defining SWITCH_DEBOUNCE_LONG_PRESS_EN.
module switch_debounce #(
    parameter int unsigned DEBOUNCE_LIMIT   = 250000,
    parameter int unsigned LONG_PRESS_LIMIT = 25000000
) (
    input  logic i_Clock,
    input  logic i_Reset_n,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Press,
    output logic o_Release,
    output logic o_Long_Press
);

    localparam int unsigned DB_CNT_W = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [DB_CNT_W-1:0] DB_ONE  = DB_CNT_W'(1);

    typedef enum logic [1:0] {
        STABLE_LOW,
        WAIT_HIGH,
        STABLE_HIGH,
        WAIT_LOW
    } state_e;

    state_e              state_q, state_d;
    logic                sync1_q, sync0_q;
    logic [DB_CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic                switch_q, switch_d;
    logic                press_q, press_d;
    logic                release_q, release_d;

    always_comb begin
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        switch_d  = switch_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            STABLE_LOW: begin
                switch_d = 1'b0;
                if (sync0_q) begin
                    state_d  = WAIT_HIGH;
                    db_cnt_d = DB_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!sync0_q) begin
                    state_d  = STABLE_LOW;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = STABLE_HIGH;
                    switch_d = 1'b1;
                    press_d  = 1'b1;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            STABLE_HIGH: begin
                switch_d = 1'b1;
                if (!sync0_q) begin
                    state_d  = WAIT_LOW;
                    db_cnt_d = DB_ONE;
                end
            end
            WAIT_LOW: begin
                if (sync0_q) begin
                    state_d  = STABLE_HIGH;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = STABLE_LOW;
                    switch_d  = 1'b0;
                    release_d = 1'b1;
                    db_cnt_d  = '0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = STABLE_LOW;
                db_cnt_d = '0;
                switch_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            sync1_q   <= 1'b0;
            sync0_q   <= 1'b0;
            state_q   <= STABLE_LOW;
            db_cnt_q  <= '0;
            switch_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= i_Switch;
            sync0_q   <= sync1_q;
            state_q   <= state_d;
            db_cnt_q  <= db_cnt_d;
            switch_q  <= switch_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign o_Switch  = switch_q;
    assign o_Press   = press_q;
    assign o_Release = release_q;

`ifdef SWITCH_DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned LP_CNT_W = $clog2(LONG_PRESS_LIMIT + 1);
    localparam logic [LP_CNT_W-1:0] LP_LAST = LP_CNT_W'(LONG_PRESS_LIMIT - 1);
    localparam logic [LP_CNT_W-1:0] LP_MAX  = LP_CNT_W'(LONG_PRESS_LIMIT);

    logic [LP_CNT_W-1:0] long_cnt_q, long_cnt_d;
    logic                long_press_q, long_press_d;

    // Saturating at the limit gives exactly one pulse per hold, however long.
    always_comb begin
        long_cnt_d   = long_cnt_q;
        long_press_d = 1'b0;
        if (!switch_q) begin
            long_cnt_d = '0;
        end else if (long_cnt_q != LP_MAX) begin
            long_cnt_d   = long_cnt_q + 1'b1;
            long_press_d = (long_cnt_q == LP_LAST);
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            long_cnt_q   <= '0;
            long_press_q <= 1'b0;
        end else begin
            long_cnt_q   <= long_cnt_d;
            long_press_q <= long_press_d;
        end
    end

    assign o_Long_Press = long_press_q;
`else
    // Constant 0; the limit is referenced only so the parameter stays part of the interface.
    assign o_Long_Press = 1'b0 && (LONG_PRESS_LIMIT >= 2);
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: directed latency/bounce scenarios plus random input
// segments, all compared every cycle against a sliding-window reference model.
module tb_switch_debounce;

    localparam int unsigned DB = 4;
    localparam int unsigned LP = 10;

    logic clk = 1'b0;
    logic rst_n;
    logic sw;
    logic o_sw, o_press, o_rel, o_long;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // reference model state
    logic        m_s1, m_s0;
    logic        m_win [DB];
    logic        m_level, m_press, m_rel, m_long;
    int unsigned m_cyc = 0;
    int unsigned m_press_cyc = 0;

    switch_debounce #(
        .DEBOUNCE_LIMIT  (DB),
        .LONG_PRESS_LIMIT(LP)
    ) dut (
        .i_Clock     (clk),
        .i_Reset_n   (rst_n),
        .i_Switch    (sw),
        .o_Switch    (o_sw),
        .o_Press     (o_press),
        .o_Release   (o_rel),
        .o_Long_Press(o_long)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // The accepted level flips once the last DB synchronized samples all disagree with it.
    task automatic model_edge(input logic s_in, input logic r_n);
        logic        s;
        int unsigned diff;
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_long  = 1'b0;
        if (!r_n) begin
            m_s1 = 1'b0;
            m_s0 = 1'b0;
            for (int i = 0; i < DB; i++) m_win[i] = 1'b0;
            m_level = 1'b0;
        end else begin
            s = m_s0;
`ifdef SWITCH_DEBOUNCE_LONG_PRESS_EN
            if (m_level && (m_cyc - m_press_cyc == LP)) m_long = 1'b1;
`endif
            m_s0 = m_s1;
            m_s1 = s_in;
            for (int i = DB - 1; i > 0; i--) m_win[i] = m_win[i-1];
            m_win[0] = s;
            diff = 0;
            for (int i = 0; i < DB; i++) if (m_win[i] != m_level) diff++;
            if (diff == DB) begin
                m_level = ~m_level;
                if (m_level) begin
                    m_press     = 1'b1;
                    m_press_cyc = m_cyc;
                end else begin
                    m_rel = 1'b1;
                end
            end
        end
        m_cyc++;
    endtask

    task automatic step(input logic s_in, input logic r_n);
        @(negedge clk);
        sw    = s_in;
        rst_n = r_n;
        @(posedge clk);
        model_edge(s_in, r_n);
        #1;
        check_eq("o_Switch", 32'(o_sw), 32'(m_level));
        check_eq("o_Press", 32'(o_press), 32'(m_press));
        check_eq("o_Release", 32'(o_rel), 32'(m_rel));
        check_eq("o_Long_Press", 32'(o_long), 32'(m_long));
        check_eq("press_release_excl", 32'(o_press & o_rel), 32'd0);
    endtask

    function automatic logic pulse_of(input int unsigned which);
        case (which)
            0:       return o_press;
            1:       return o_rel;
            default: return o_long;
        endcase
    endfunction

    // Drives a level for exactly maxn cycles; reports the step index of the first pulse and the pulse count.
    task automatic run_until(input logic s_in, input int unsigned maxn, input int unsigned which,
                             output int unsigned lat, output int unsigned npulse);
        lat    = 0;
        npulse = 0;
        for (int unsigned n = 1; n <= maxn; n++) begin
            step(s_in, 1'b1);
            if (pulse_of(which)) begin
                npulse++;
                if (lat == 0) lat = n;
            end
        end
    endtask

    initial begin
        int unsigned lat, np, len;
        logic        v;
        sw    = 1'b1;
        rst_n = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0);
            check_eq("reset_outputs", {28'd0, o_sw, o_press, o_rel, o_long}, 32'd0);
        end
        run_until(1'b1, 10, 0, lat, np);
        check_eq("reset_hold_press_lat", lat, 6);
        check_eq("reset_hold_press_cnt", np, 1);

        run_until(1'b0, 3, 1, lat, np);
        check_eq("glitch_no_release_a", np, 0);
        run_until(1'b1, 8, 1, lat, np);
        check_eq("glitch_no_release_b", np, 0);
        check_eq("glitch_level_high", 32'(o_sw), 32'd1);

        run_until(1'b0, 10, 1, lat, np);
        check_eq("release_lat", lat, 6);
        check_eq("release_cnt", np, 1);

        run_until(1'b1, 3, 0, lat, np);
        check_eq("bounce_no_press", np, 0);
        step(1'b0, 1'b1);
        run_until(1'b1, 10, 0, lat, np);
        check_eq("bounce_press_lat", lat, 6);

        run_until(1'b0, 10, 1, lat, np);
        check_eq("release2_lat", lat, 6);
        run_until(1'b1, 6, 0, lat, np);
        check_eq("clean_press_lat", lat, 6);
        run_until(1'b1, 40, 2, lat, np);
`ifdef SWITCH_DEBOUNCE_LONG_PRESS_EN
        check_eq("long_press_lat", lat, LP);
        check_eq("long_press_cnt", np, 1);
`else
        check_eq("long_press_lat", lat, 0);
        check_eq("long_press_cnt", np, 0);
`endif

        for (int seg = 0; seg < 200; seg++) begin
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 14);
            if ($urandom_range(0, 49) == 0) begin
                step(v, 1'b0);
            end else begin
                for (int unsigned k = 0; k < len; k++) step(v, 1'b1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
